// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the SPI frame receiver.
// Frame geometry and SPI-mode decoding are computed here so top and bench agree.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_e;

  function automatic int spi_total_w(input int opcode_w, input int data_w, input int n_words);
    return opcode_w + n_words * data_w;
  endfunction

  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
  function automatic bit spi_sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection
// derived from one extra flop behind the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI slave that collects one opcode plus N_WORDS data words per
// chip-select window and presents the frame on a valid/ready handshake.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int OPCODE_W    = 8,
  parameter int DATA_W      = 16,
  parameter int N_WORDS     = 5,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk_sys,
  input  logic                            rst,
  input  logic                            spi_sclk,
  input  logic                            spi_csb,
  input  logic                            spi_mosi,
  output logic [OPCODE_W-1:0]             opcode,
  output logic [N_WORDS-1:0][DATA_W-1:0]  data,
  output logic                            valid,
  input  logic                            ready,
  output logic                            busy,
  output logic                            overrun,
  output logic                            frame_err
);

  localparam int TOTAL_W     = spi_total_w(OPCODE_W, DATA_W, N_WORDS);
  localparam int CNT_W       = $clog2(TOTAL_W + 1);
  localparam bit SAMPLE_RISE = spi_sample_on_rise(CPOL != 0, CPHA != 0);

  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_csb, w_csb_rise, w_csb_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sync_sclk (
    .clk_sys(clk_sys), .rst(rst), .i_pin(spi_sclk),
    .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk_sys(clk_sys), .rst(rst), .i_pin(spi_csb),
    .o_level(w_csb), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_sys(clk_sys), .rst(rst), .i_pin(spi_mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_e                      r_state, w_state_next;
  logic [CNT_W-1:0]            r_count;
  logic [TOTAL_W-1:0]          r_sr;
  logic                        r_done;
  logic                        r_valid, r_overrun, r_frame_err;
  logic [OPCODE_W-1:0]         r_opcode;
  logic [N_WORDS-1:0][DATA_W-1:0] r_data;

  logic                        w_sample, w_last, w_shift_en, w_done_next, w_frame_err_next;
  logic [OPCODE_W-1:0]         w_opcode;
  logic [N_WORDS-1:0][DATA_W-1:0] w_data;

  // A csb rise seen together with the final edge still counts as inside the frame.
  assign w_sample = (SAMPLE_RISE ? w_sclk_rise : w_sclk_fall) && (!w_csb || w_csb_rise);
  assign w_last   = (r_count == CNT_W'(TOTAL_W - 1));

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_shift_en       = 1'b0;
    w_done_next      = 1'b0;
    w_frame_err_next = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_csb_fall) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          if (w_last) begin
            w_done_next  = 1'b1;
            w_state_next = WAIT_CS;
          end
        end else if (w_csb) begin
          w_frame_err_next = (r_count != '0);
          w_state_next     = IDLE;
        end
      end
      WAIT_CS: begin
        if (w_csb) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_opcode = r_sr[TOTAL_W-1 -: OPCODE_W];
    for (int i = 0; i < N_WORDS; i++) begin
      w_data[i] = r_sr[TOTAL_W-OPCODE_W-1-i*DATA_W -: DATA_W];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_count     <= '0;
      r_sr        <= '0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_opcode    <= '0;
      r_data      <= '0;
    end else begin
      r_done      <= w_done_next;
      r_frame_err <= w_frame_err_next;
      r_overrun   <= 1'b0;

      if (r_state == IDLE && w_csb_fall) begin
        r_count <= '0;
      end else if (w_shift_en && r_count != CNT_W'(TOTAL_W)) begin
        r_count <= r_count + CNT_W'(1);
      end

      if (w_shift_en) r_sr <= {r_sr[TOTAL_W-2:0], w_mosi};

      // A completed frame may replace the held one only in the cycle it is consumed.
      if (r_done && (!r_valid || ready)) begin
        r_opcode <= w_opcode;
        r_data   <= w_data;
        r_valid  <= 1'b1;
      end else begin
        if (r_valid && ready) r_valid <= 1'b0;
        if (r_done)           r_overrun <= 1'b1;
      end
    end
  end

  assign opcode    = r_opcode;
  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench: mode 0 receiver checked in depth, modes 1 and 3 checked for
// identical capture of the same frame driven on their own sclk lines.
module tb_spi_frame_rx;

  localparam int H = 4;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  logic sclk0   = 1'b0;
  logic sclk1   = 1'b0;
  logic sclk3   = 1'b1;
  logic csb     = 1'b1;
  logic mosi    = 1'b0;
  logic ready   = 1'b1;
  logic ready_hi = 1'b1;

  logic [7:0]       op0, op1, op3;
  logic [4:0][15:0] data0, data1, data3;
  logic             valid0, valid1, valid3;
  logic             busy0, busy1, busy3;
  logic             ovr0, ovr1, ovr3;
  logic             ferr0, ferr1, ferr3;

  always #5 clk_sys = ~clk_sys;

  spi_frame_rx #(.CPOL(0), .CPHA(0)) u_dut0 (
    .clk_sys(clk_sys), .rst(rst), .spi_sclk(sclk0), .spi_csb(csb), .spi_mosi(mosi),
    .opcode(op0), .data(data0), .valid(valid0), .ready(ready),
    .busy(busy0), .overrun(ovr0), .frame_err(ferr0)
  );

  spi_frame_rx #(.CPOL(0), .CPHA(1)) u_dut1 (
    .clk_sys(clk_sys), .rst(rst), .spi_sclk(sclk1), .spi_csb(csb), .spi_mosi(mosi),
    .opcode(op1), .data(data1), .valid(valid1), .ready(ready_hi),
    .busy(busy1), .overrun(ovr1), .frame_err(ferr1)
  );

  spi_frame_rx #(.CPOL(1), .CPHA(1)) u_dut3 (
    .clk_sys(clk_sys), .rst(rst), .spi_sclk(sclk3), .spi_csb(csb), .spi_mosi(mosi),
    .opcode(op3), .data(data3), .valid(valid3), .ready(ready_hi),
    .busy(busy3), .overrun(ovr3), .frame_err(ferr3)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt0 = 0, vcnt1 = 0, vcnt3 = 0;
  int ovr_cnt = 0, ferr_cnt = 0;
  int edge_cyc = 0, valid_rise_cyc = 0;
  logic valid0_q = 1'b0;
  logic [7:0]       cap_op0, cap_op1, cap_op3;
  logic [4:0][15:0] cap_d0, cap_d1, cap_d3;

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (valid0) begin
      vcnt0++;
      cap_op0 = op0;
      cap_d0  = data0;
      if (!valid0_q) valid_rise_cyc = cyc;
    end
    valid0_q = valid0;
    if (valid1) begin vcnt1++; cap_op1 = op1; cap_d1 = data1; end
    if (valid3) begin vcnt3++; cap_op3 = op3; cap_d3 = data3; end
    if (ovr0)  ovr_cnt++;
    if (ferr0) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends n bits MSB first (bits past 88 are ones); rst_at >= 0 resets mid-frame.
  task automatic xfer(input logic [87:0] f, input int n, input int rst_at);
    tick(1);
    csb = 1'b0;
    tick(H);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        check("rst_valid",  valid0, 0);
        check("rst_opcode", op0, 0);
        check("rst_data",   data0, 0);
        check("rst_busy",   busy0, 0);
        tick(1);
        csb   = 1'b1;
        sclk0 = 1'b0;
        sclk1 = 1'b0;
        sclk3 = 1'b1;
        tick(8);
        rst = 1'b0;
        tick(4);
        return;
      end
      mosi  = (i < 88) ? f[87-i] : 1'b1;
      sclk0 = 1'b0;
      sclk1 = 1'b0;
      sclk3 = 1'b0;
      tick(H);
      sclk0 = 1'b1;
      sclk1 = 1'b1;
      sclk3 = 1'b1;
      if (i == 87) edge_cyc = cyc;
      tick(H);
      sclk0 = 1'b0;
      sclk1 = 1'b0;
      tick(H);
    end
    csb = 1'b1;
    tick(24);
  endtask

  localparam logic [87:0] F1  = {8'hA5, 16'h1234, 16'hBEEF, 16'h0001, 16'h8000, 16'hFFFF};
  localparam logic [79:0] D1  = {16'hFFFF, 16'h8000, 16'h0001, 16'hBEEF, 16'h1234};
  localparam logic [87:0] FA  = {8'h11, 16'h1101, 16'h1102, 16'h1103, 16'h1104, 16'h1105};
  localparam logic [79:0] DA  = {16'h1105, 16'h1104, 16'h1103, 16'h1102, 16'h1101};
  localparam logic [87:0] FB  = {8'h22, 16'h2201, 16'h2202, 16'h2203, 16'h2204, 16'h2205};
  localparam logic [87:0] F3C = {8'h3C, 16'h0F0F, 16'hF0F0, 16'h5A5A, 16'hA5A5, 16'h0000};
  localparam logic [79:0] D3C = {16'h0000, 16'hA5A5, 16'h5A5A, 16'hF0F0, 16'h0F0F};
  localparam logic [87:0] F5  = {8'hC3, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h7E57};
  localparam logic [79:0] D5  = {16'h7E57, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};

  int v0, v1, v3, o0, e0;

  task automatic snap();
    v0 = vcnt0; v1 = vcnt1; v3 = vcnt3; o0 = ovr_cnt; e0 = ferr_cnt;
  endtask

  initial begin
    tick(5);
    check("reset_valid",     valid0, 0);
    check("reset_opcode",    op0, 0);
    check("reset_data",      data0, 0);
    check("reset_busy",      busy0, 0);
    check("reset_overrun",   ovr0, 0);
    check("reset_frame_err", ferr0, 0);
    rst = 1'b0;
    tick(5);

    // Basic frame in all three modes
    ready = 1'b1;
    snap();
    xfer(F1, 88, -1);
    check("t1_valid_pulses", vcnt0 - v0, 1);
    check("t1_opcode",       cap_op0, 8'hA5);
    check("t1_data",         cap_d0, D1);
    check("t1_data0",        cap_d0[0], 16'h1234);
    check("t1_latency",      valid_rise_cyc - edge_cyc, 4);
    check("t1_valid_low",    valid0, 0);
    check("t1_no_overrun",   ovr_cnt - o0, 0);
    check("t1_no_frame_err", ferr_cnt - e0, 0);
    check("t2_m1_pulses",    vcnt1 - v1, 1);
    check("t2_m1_opcode",    cap_op1, 8'hA5);
    check("t2_m1_data",      cap_d1, D1);
    check("t2_m3_pulses",    vcnt3 - v3, 1);
    check("t2_m3_opcode",    cap_op3, 8'hA5);
    check("t2_m3_data",      cap_d3, D1);

    // Overrun while the consumer stalls
    ready = 1'b0;
    snap();
    xfer(FA, 88, -1);
    check("t3_first_valid",  valid0, 1);
    check("t3_first_opcode", op0, 8'h11);
    xfer(FB, 88, -1);
    check("t3_overrun",      ovr_cnt - o0, 1);
    check("t3_hold_valid",   valid0, 1);
    check("t3_hold_opcode",  op0, 8'h11);
    check("t3_hold_data",    data0, DA);
    ready = 1'b1;
    @(posedge clk_sys);
    #1;
    check("t3_valid_drop",   valid0, 0);
    tick(4);

    // Chip select released early, then a clean frame
    snap();
    xfer(F1, 20, -1);
    check("t4_frame_err",    ferr_cnt - e0, 1);
    check("t4_no_valid",     vcnt0 - v0, 0);
    check("t4_busy_idle",    busy0, 0);
    snap();
    xfer(F3C, 88, -1);
    check("t4_next_pulses",  vcnt0 - v0, 1);
    check("t4_next_opcode",  cap_op0, 8'h3C);
    check("t4_next_data",    cap_d0, D3C);
    check("t4_next_no_err",  ferr_cnt - e0, 0);

    // Extra clocks past the frame are ignored
    snap();
    xfer(F5, 100, -1);
    check("t5_pulses",       vcnt0 - v0, 1);
    check("t5_opcode",       cap_op0, 8'hC3);
    check("t5_data",         cap_d0, D5);
    check("t5_no_frame_err", ferr_cnt - e0, 0);
    check("t5_no_overrun",   ovr_cnt - o0, 0);

    // Reset mid-frame with a frame held, then recovery
    ready = 1'b0;
    xfer(FA, 88, -1);
    check("t6_pre_valid",    valid0, 1);
    xfer(FB, 88, 40);
    ready = 1'b1;
    snap();
    xfer(F1, 88, -1);
    check("t6_pulses",       vcnt0 - v0, 1);
    check("t6_opcode",       cap_op0, 8'hA5);
    check("t6_data",         cap_d0, D1);
    check("t6_no_frame_err", ferr_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
